// File: rtl/mux_pkt_arbiter.sv
// Packet-level round-robin arbiter for the 2:1 router output mux.
// Grants one port per packet from HEAD to TAIL and drives the consume strobes.
module mux_pkt_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            ivalid_0,
    input  logic [1:0]      itype_0,
    input  logic            ivalid_1,
    input  logic [1:0]      itype_1,
    input  logic            oready,
    output logic [1:0]      sel,
    output logic            grant_0,
    output logic            grant_1,
    output logic            busy,
    output logic [CNTW-1:0] flit_cnt,
    output logic            err
);

    localparam logic [1:0] TYPE_NONE = 2'b00;
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_DATA = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;
    localparam int         TO_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              prio_q, prio_d;
    logic [1:0]        sel_q, sel_d;
    logic              busy_q, busy_d;
    logic [CNTW-1:0]   flit_cnt_q, flit_cnt_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

    logic              req_0, req_1;
    logic              lk_port;
    logic              lk_valid;
    logic [1:0]        lk_type;
    logic              xfer;

    assign req_0 = ivalid_0 && (itype_0 == TYPE_HEAD);
    assign req_1 = ivalid_1 && (itype_1 == TYPE_HEAD);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        flit_cnt_d = flit_cnt_q;
        err_d      = err_q;
        to_cnt_d   = to_cnt_q;
        grant_0    = 1'b0;
        grant_1    = 1'b0;
        lk_port    = (state_q == LOCK1);
        lk_valid   = lk_port ? ivalid_1 : ivalid_0;
        lk_type    = lk_port ? itype_1  : itype_0;
        xfer       = 1'b0;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (req_0 && (!req_1 || !prio_q)) begin
                    state_d    = LOCK0;
                    flit_cnt_d = '0;
                end else if (req_1) begin
                    state_d    = LOCK1;
                    flit_cnt_d = '0;
                end
            end
            LOCK0, LOCK1: begin
                xfer    = lk_valid && oready;
                grant_0 = xfer && !lk_port;
                grant_1 = xfer &&  lk_port;
                if (lk_valid) begin
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Port went silent mid-packet: release it and flag it.
                    err_d    = 1'b1;
                    state_d  = IDLE;
                    prio_d   = ~lk_port;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
                if (xfer) begin
                    if (flit_cnt_q != '1) begin
                        flit_cnt_d = flit_cnt_q + 1'b1;
                    end
                    if ((lk_type == TYPE_HEAD && flit_cnt_q != '0) || lk_type == TYPE_NONE) begin
                        err_d = 1'b1;
                    end
                    if (lk_type == TYPE_TAIL) begin
                        state_d = IDLE;
                        prio_d  = ~lk_port;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        sel_d  = (state_d == LOCK0) ? 2'b01 : (state_d == LOCK1) ? 2'b10 : 2'b00;
        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            sel_q      <= 2'b00;
            busy_q     <= 1'b0;
            flit_cnt_q <= '0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
            flit_cnt_q <= flit_cnt_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign sel      = sel_q;
    assign busy     = busy_q;
    assign flit_cnt = flit_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// Directed self-checking bench for mux_pkt_arbiter.
// Inputs change 1 ns after each rising edge; outputs are checked 1 ns later.
module tb_mux_pkt_arbiter;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    logic       clk;
    logic       rst_;
    logic       ivalid_0, ivalid_1, oready;
    logic [1:0] itype_0, itype_1;
    logic [1:0] sel;
    logic       grant_0, grant_1, busy, err;
    logic [7:0] flit_cnt;

    int errors = 0;
    int checks = 0;

    mux_pkt_arbiter #(.TIMEOUT(64), .CNTW(8)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .ivalid_0 (ivalid_0),
        .itype_0  (itype_0),
        .ivalid_1 (ivalid_1),
        .itype_1  (itype_1),
        .oready   (oready),
        .sel      (sel),
        .grant_0  (grant_0),
        .grant_1  (grant_1),
        .busy     (busy),
        .flit_cnt (flit_cnt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the edge, leave time for grants to settle.
    task automatic cyc(input logic v0, input logic [1:0] t0,
                       input logic v1, input logic [1:0] t1, input logic rdy);
        @(posedge clk);
        #1;
        ivalid_0 = v0;
        itype_0  = t0;
        ivalid_1 = v1;
        itype_1  = t1;
        oready   = rdy;
        #1;
    endtask

    task automatic do_reset();
        ivalid_0 = 1'b0; itype_0 = T_NONE;
        ivalid_1 = 1'b0; itype_1 = T_NONE;
        oready   = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        #2;
        rst_ = 1'b1;
    endtask

    initial begin
        logic [1:0] typ;

        // Reset and idle
        rst_ = 1'b0;
        ivalid_0 = 1'b0; itype_0 = T_NONE;
        ivalid_1 = 1'b0; itype_1 = T_NONE;
        oready   = 1'b1;
        #3;
        check("rst_sel", sel, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cnt", flit_cnt, 8'd0);
        check("rst_g0", grant_0, 1'b0);
        check("rst_g1", grant_1, 1'b0);
        @(negedge clk);
        #2;
        rst_ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, T_NONE, 1'b0, T_NONE, 1'b1);
            check("idle_sel", sel, 2'b00);
            check("idle_busy", busy, 1'b0);
            check("idle_err", err, 1'b0);
            check("idle_grants", {grant_1, grant_0}, 2'b00);
        end

        // Single packet on port 1: HEAD + 20 DATA + TAIL
        cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
        check("p1_head_wait_sel", sel, 2'b00);
        check("p1_head_wait_g1", grant_1, 1'b0);
        for (int i = 0; i < 22; i++) begin
            typ = (i == 0) ? T_HEAD : (i == 21) ? T_TAIL : T_DATA;
            cyc(1'b0, T_NONE, 1'b1, typ, 1'b1);
            check("p1_sel", sel, 2'b10);
            check("p1_busy", busy, 1'b1);
            check("p1_g1", grant_1, 1'b1);
            check("p1_g0", grant_0, 1'b0);
            check("p1_cnt", flit_cnt, 32'(i));
        end
        cyc(1'b0, T_NONE, 1'b0, T_NONE, 1'b1);
        check("p1_done_sel", sel, 2'b00);
        check("p1_done_busy", busy, 1'b0);
        check("p1_done_cnt", flit_cnt, 8'd22);
        check("p1_done_err", err, 1'b0);

        // Contention right after reset: port 0 first, then port 1
        do_reset();
        cyc(1'b1, T_HEAD, 1'b1, T_HEAD, 1'b1);
        check("tie_idle_grants", {grant_1, grant_0}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            typ = (i == 0) ? T_HEAD : (i == 3) ? T_TAIL : T_DATA;
            cyc(1'b1, typ, 1'b1, T_HEAD, 1'b1);
            check("tie_p0_sel", sel, 2'b01);
            check("tie_p0_grants", {grant_1, grant_0}, 2'b01);
        end
        cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
        check("tie_bubble_sel", sel, 2'b00);
        check("tie_bubble_grants", {grant_1, grant_0}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            typ = (i == 0) ? T_HEAD : (i == 3) ? T_TAIL : T_DATA;
            cyc(1'b0, T_NONE, 1'b1, typ, 1'b1);
            check("tie_p1_sel", sel, 2'b10);
            check("tie_p1_grants", {grant_1, grant_0}, 2'b10);
        end
        cyc(1'b1, T_HEAD, 1'b1, T_HEAD, 1'b1);
        check("tie2_idle_sel", sel, 2'b00);
        cyc(1'b1, T_HEAD, 1'b0, T_NONE, 1'b1);
        check("tie2_sel", sel, 2'b01);
        check("tie2_grants", {grant_1, grant_0}, 2'b01);
        cyc(1'b1, T_TAIL, 1'b0, T_NONE, 1'b1);
        check("tie2_tail_g0", grant_0, 1'b1);
        cyc(1'b0, T_NONE, 1'b0, T_NONE, 1'b1);
        check("tie2_done_sel", sel, 2'b00);
        check("tie2_done_err", err, 1'b0);

        // Backpressure: 5 stall cycles in the middle of a 10-flit packet
        cyc(1'b1, T_HEAD, 1'b0, T_NONE, 1'b1);
        check("bp_idle_sel", sel, 2'b00);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                for (int s = 0; s < 5; s++) begin
                    cyc(1'b1, T_DATA, 1'b0, T_NONE, 1'b0);
                    check("bp_stall_g0", grant_0, 1'b0);
                    check("bp_stall_cnt", flit_cnt, 8'd5);
                    check("bp_stall_sel", sel, 2'b01);
                end
            end
            typ = (i == 0) ? T_HEAD : (i == 9) ? T_TAIL : T_DATA;
            cyc(1'b1, typ, 1'b0, T_NONE, 1'b1);
            check("bp_g0", grant_0, 1'b1);
            check("bp_cnt", flit_cnt, 32'(i));
        end
        cyc(1'b0, T_NONE, 1'b0, T_NONE, 1'b1);
        check("bp_done_cnt", flit_cnt, 8'd10);
        check("bp_done_sel", sel, 2'b00);
        check("bp_done_err", err, 1'b0);

        // Timeout: port 0 locks then goes silent for 64 cycles, port 1 waits
        cyc(1'b1, T_HEAD, 1'b0, T_NONE, 1'b1);
        cyc(1'b1, T_HEAD, 1'b0, T_NONE, 1'b1);
        check("to_head_g0", grant_0, 1'b1);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
            check("to_wait_sel", sel, 2'b01);
            check("to_wait_err", err, 1'b0);
            check("to_wait_g1", grant_1, 1'b0);
        end
        cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
        check("to_fire_sel", sel, 2'b00);
        check("to_fire_busy", busy, 1'b0);
        check("to_fire_err", err, 1'b1);
        check("to_fire_g1", grant_1, 1'b0);
        cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
        check("to_next_sel", sel, 2'b10);
        check("to_next_g1", grant_1, 1'b1);
        cyc(1'b0, T_NONE, 1'b1, T_TAIL, 1'b1);
        check("to_next_tail_g1", grant_1, 1'b1);

        // Protocol error: HEAD mid-packet on the locked port, then async reset
        do_reset();
        check("pe_reset_err", err, 1'b0);
        cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
        cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
        check("pe_head_g1", grant_1, 1'b1);
        cyc(1'b0, T_NONE, 1'b1, T_DATA, 1'b1);
        check("pe_data_err", err, 1'b0);
        cyc(1'b0, T_NONE, 1'b1, T_HEAD, 1'b1);
        check("pe_bad_head_g1", grant_1, 1'b1);
        cyc(1'b0, T_NONE, 1'b1, T_DATA, 1'b1);
        check("pe_err_set", err, 1'b1);
        check("pe_sel", sel, 2'b10);
        check("pe_cnt", flit_cnt, 8'd3);
        rst_ = 1'b0;
        #1;
        check("ar_err", err, 1'b0);
        check("ar_sel", sel, 2'b00);
        check("ar_busy", busy, 1'b0);
        check("ar_cnt", flit_cnt, 8'd0);
        check("ar_g1", grant_1, 1'b0);
        #2;
        rst_ = 1'b1;
        cyc(1'b0, T_NONE, 1'b0, T_NONE, 1'b1);
        check("post_rst_sel", sel, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_pkt_arbiter.md
# mux_pkt_arbiter

Packet-level round-robin arbiter that drives the `sel` input of the 2:1 router output mux. It grants one input port per packet, starting on a HEAD flit and ending after the TAIL flit, so flits of different packets never interleave on `odata`. It also returns per-port consume strobes to the input buffers and honours downstream backpressure. It sits beside the mux in each router output stage.

## Interface
- `TYPE_NONE`, 2'b00, flit type code: idle/no flit.
- `TYPE_HEAD`, 2'b01, flit type code: head flit (opens a packet).
- `TYPE_DATA`, 2'b10, flit type code: payload flit.
- `TYPE_TAIL`, 2'b11, flit type code: tail flit (closes a packet).
- `TIMEOUT`, 64, idle cycles tolerated on a locked port before forced release (≥2).
- `CNTW`, 8, width of the per-packet flit counter.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rst_`  in  1  reset; asynchronous, active-low.
- `ivalid_0`  in  1  port 0 flit valid.
- `itype_0`  in  2  port 0 flit type (top 2 bits of `idata_0`).
- `ivalid_1`  in  1  port 1 flit valid.
- `itype_1`  in  2  port 1 flit type.
- `oready`  in  1  downstream accepts a flit this cycle.
- `sel`  out  2  one-hot mux select: 2'b01 = port 0, 2'b10 = port 1, 2'b00 = none. Registered.
- `grant_0`  out  1  port 0 flit consumed this cycle. Combinational.
- `grant_1`  out  1  port 1 flit consumed this cycle. Combinational.
- `busy`  out  1  a packet is locked. Registered.
- `flit_cnt`  out  CNTW  flits forwarded in the current packet, head included. Registered.
- `err`  out  1  sticky protocol error. Cleared only by reset.

## Operation
- States: IDLE, LOCK0, LOCK1. Round-robin pointer `prio` (0 or 1) holds the preferred port.
- Request: `req_k = ivalid_k && itype_k == TYPE_HEAD`.
- IDLE
  - If no request: stay in IDLE.
  - If only port k requests: go to LOCKk.
  - If both request: go to LOCK(`prio`).
  - `sel` and `busy` are updated on the same edge as the state change. No flit is consumed in IDLE.
- LOCKk
  - Transfer: `grant_k = ivalid_k && oready`. The other grant is 0.
  - On each transfer, `flit_cnt` increments and saturates at 2^CNTW-1.
  - On a TAIL transfer: go to IDLE, set `prio = 1-k`, `sel = 00`, `busy = 0`. `flit_cnt` holds its final value until the next lock.
  - HEAD seen during a transfer in LOCKk (head not at packet start): set `err`. The flit is still forwarded.
  - TYPE_NONE seen with `ivalid_k` high: set `err`. The flit is still forwarded.
- Timeout counter
  - Counts consecutive LOCK cycles with `ivalid_k == 0`. It resets on any valid cycle and while in IDLE.
  - When it reaches TIMEOUT: set `err`, go to IDLE, set `prio = 1-k`.
  - Stalls caused by `oready == 0` are not counted.
- Entering LOCKk resets `flit_cnt` to 0.

## Timing
- Reset values: state IDLE, `sel` 2'b00, `busy` 0, `flit_cnt` 0, `err` 0, `prio` 0, timeout counter 0. `grant_*` are 0 because they depend on state.
- Latency: a HEAD valid on cycle N (in IDLE) gives `sel`/`busy` on N+1. The head is consumed on N+1 at the earliest (`grant_k` high when `oready`).
- Throughput while locked: 1 flit/cycle.
- After a TAIL transfer on cycle T, `sel = 00` on T+1. A new lock can be visible on T+2. Minimum per-packet overhead is 1 bubble cycle.
- `oready` low: `grant_k` low and the flit is held upstream; state, `sel` and counters are unchanged.
- Simultaneous events:
  - Both heads in IDLE: `prio` wins; the loser waits, and its grant stays 0.
  - TAIL transfer and timeout in the same cycle: the transfer wins, `err` is not set.
- Reset asserted mid-packet: all registers return to reset values immediately (async). `grant_*` drop in the same cycle.

## Test plan
- Reset and idle
  - Stimulus: `rst_` low, then high, with `ivalid_*` = 0 for 10 cycles.
  - Required: `sel` = 00, `busy` = 0, `err` = 0, `grant_*` = 0 throughout.
- Single packet, port 1
  - Stimulus: HEAD + 20 DATA + TAIL on port 1, `oready` = 1.
  - Required: `sel` = 10 one cycle after the head; `grant_1` high for 22 cycles; `flit_cnt` = 22; `sel` = 00 the cycle after the tail.
- Contention
  - Stimulus: heads on both ports at the same cycle after reset, each packet 4 flits.
  - Required: port 0 served first (`sel` = 01); then port 1 (`sel` = 10) after a 1-cycle bubble; `grant_0` and `grant_1` never high together; next tie goes to port 0.
- Backpressure
  - Stimulus: `oready` low for 5 cycles in the middle of a 10-flit packet.
  - Required: `grant` = 0 during the stall; no timeout; `flit_cnt` frozen; packet completes with `flit_cnt` = 10.
- Timeout
  - Stimulus: port 0 sends a HEAD, then `ivalid_0` = 0 for 64 cycles.
  - Required: `err` = 1, state back to IDLE, `sel` = 00; a pending port 1 head is locked on the next cycle.
- Protocol error and async reset
  - Stimulus: a HEAD mid-packet on the locked port.
  - Required: `err` = 1 and the flit is still granted.
  - Stimulus: then `rst_` low while locked.
  - Required: `err` = 0, `sel` = 00, `busy` = 0 without waiting for a clock edge.
